fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Sequences up to NUM_SOURCES draw engines (background, sprites, HUD) onto the single write port of the double-buffered frame store, once per frame. On each frame pulse it starts enabled sources one at a time in fixed painter's order (index 0 first, drawn underneath), muxes the granted source's pixel stream into a registered write bus, and reports frame completion and overrun. It sits between the draw engines and the frame buffer write side.

## Interface
Parameters:
- NUM_SOURCES, 4, number of draw engines (≥2)
- DRAW_WIDTH, 640, horizontal pixel count; XW = $clog2(DRAW_WIDTH)
- DRAW_HEIGHT, 480, vertical pixel count; YW = $clog2(DRAW_HEIGHT)
- COLOR_DEPTH, 9, color bits per pixel
- TIMEOUT_CYCLES, 65535, watchdog limit per source (see Configuration)

Ports:
- clk  in  1  system clock, single clock domain
- resetN  in  1  asynchronous active-low reset
- frame  in  1  one-cycle frame-start pulse
- src_enable  in  NUM_SOURCES  per-source enable, sampled in START
- src_start  out  NUM_SOURCES  one-cycle start pulse to the granted source
- src_valid  in  NUM_SOURCES  source pixel valid
- src_done  in  NUM_SOURCES  one-cycle end-of-drawing pulse
- src_x_addr  in  NUM_SOURCES*XW  packed; source i at [i*XW +: XW]
- src_y_addr  in  NUM_SOURCES*YW  packed likewise
- src_color  in  NUM_SOURCES*COLOR_DEPTH  packed likewise
- src_transparent  in  NUM_SOURCES  per-source transparent flag
- write_active, write_transparent  out  1  registered write strobe / flag
- write_x_addr  out  XW, write_y_addr  out  YW, write_color_data  out  COLOR_DEPTH
- grant_sel  out  $clog2(NUM_SOURCES)  index of current source
- frame_done  out  1  one-cycle pulse when all sources finished
- overrun  out  1  sticky: frame arrived while not IDLE
- timeout_flags  out  NUM_SOURCES  sticky per-source watchdog flags

## Operation
- States: IDLE, START, DRAW, NEXT, DONE.
- IDLE: on frame → grant_sel=0, START.
- START: src_enable[grant_sel]=1 → src_start[grant_sel] pulses this cycle, DRAW; else → NEXT (no pulse).
- DRAW: forward granted source's bus; src_done[grant_sel] → NEXT. Done from non-granted sources ignored.
- NEXT: grant_sel==NUM_SOURCES-1 → DONE; else grant_sel+1, START.
- DONE: frame_done=1 one cycle → IDLE, grant_sel=0.
- frame while not IDLE: ignored for sequencing, overrun set; cleared only by reset.
- frame in the same cycle DONE→IDLE: ignored (overrun set); next frame pulse starts.
- Non-granted src_valid ignored; src_start never asserted to two sources.
- All sources disabled: frame → DONE in 2*NUM_SOURCES+1 cycles, no write_active.

## Timing
- Reset: state IDLE, grant_sel 0, all outputs 0, sticky flags cleared.
- Write bus latency 1 cycle: write_active(t+1) = (state==DRAW) && src_valid[grant_sel](t); address/color/transparent registered same cycle.
- Valid coincident with src_done is forwarded (last pixel kept).
- Source may assert valid from the cycle after src_start.
- Reset mid-DRAW: bus cleared immediately, no frame_done, next frame restarts from source 0.

## Configuration
- FB_SCHED_TIMEOUT_EN defined: cycle counter cleared on DRAW entry; reaching TIMEOUT_CYCLES in DRAW → forced NEXT, timeout_flags[grant_sel] set (sticky until reset); pixels from that source are dropped after the forced exit.
- Undefined: no counter; DRAW waits indefinitely for src_done; timeout_flags tied 0.

## Structure
- Package fb_sched_pkg: state enum typedef, XW/YW width helper functions.
- Sub-module fb_sched_watchdog (counter, clear, expire output), instantiated only under FB_SCHED_TIMEOUT_EN.

## Test plan
- NUM_SOURCES=4, all enabled, each source 3 valid pixels then done → 12 write_active pulses in order 0,1,2,3, each 1 cycle after src_valid; single frame_done.
- src_enable=4'b1010 → src_start only for sources 1 and 3; grant_sel passes 0,1,2,3; frame_done after source 3's done.
- Second frame pulse during source 2 DRAW → overrun=1, sequence completes unaffected, overrun stays 1 until resetN low.
- Source 1 never signals done, TIMEOUT_CYCLES=16, macro defined → NEXT after 16 DRAW cycles, timeout_flags=4'b0010, frame completes.
- Non-granted source 3 asserts valid/done while source 0 granted → no write_active from it, no state change.
- resetN low mid-DRAW of source 2 → all outputs 0 asynchronously; next frame restarts at source 0.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// Shared types and width helpers for the frame-buffer write scheduler.
// Optional watchdog feature is enabled with the FB_SCHED_TIMEOUT_EN macro.
package fb_sched_pkg;

  // Sequencer states: one pass of START/DRAW/NEXT per source, then DONE
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } sched_state_t;

  // Width of a horizontal pixel address for a given line width
  function automatic int x_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Width of a vertical pixel address for a given frame height
  function automatic int y_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/fb_sched_watchdog.sv
// DRAW-phase watchdog: counts cycles while run is high and flags expiry
// after LIMIT cycles. Only built when FB_SCHED_TIMEOUT_EN is defined.
module fb_sched_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic resetN,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count DRAW cycles; any cycle outside DRAW rearms the counter at zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expire) begin
      count <= count + 1'b1;
    end
  end

  // Expiry lands on the last allowed DRAW cycle so the FSM leaves right after
  assign expire = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write scheduler: on each frame pulse, starts the enabled draw
// engines one at a time in painter's order (source 0 underneath) and muxes
// the granted engine's pixel stream onto a registered write bus.
// Optional per-source watchdog: define FB_SCHED_TIMEOUT_EN.
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_SOURCES    = 4,
  parameter int DRAW_WIDTH     = 640,
  parameter int DRAW_HEIGHT    = 480,
  parameter int COLOR_DEPTH    = 9,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                          clk,
  input  logic                                          resetN,
  input  logic                                          frame,
  input  logic [NUM_SOURCES-1:0]                        src_enable,
  output logic [NUM_SOURCES-1:0]                        src_start,
  input  logic [NUM_SOURCES-1:0]                        src_valid,
  input  logic [NUM_SOURCES-1:0]                        src_done,
  input  logic [NUM_SOURCES*x_width(DRAW_WIDTH)-1:0]    src_x_addr,
  input  logic [NUM_SOURCES*y_width(DRAW_HEIGHT)-1:0]   src_y_addr,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0]            src_color,
  input  logic [NUM_SOURCES-1:0]                        src_transparent,
  output logic                                          write_active,
  output logic                                          write_transparent,
  output logic [x_width(DRAW_WIDTH)-1:0]                write_x_addr,
  output logic [y_width(DRAW_HEIGHT)-1:0]               write_y_addr,
  output logic [COLOR_DEPTH-1:0]                        write_color_data,
  output logic [$clog2(NUM_SOURCES)-1:0]                grant_sel,
  output logic                                          frame_done,
  output logic                                          overrun,
  output logic [NUM_SOURCES-1:0]                        timeout_flags
);

  localparam int XW = x_width(DRAW_WIDTH);
  localparam int YW = y_width(DRAW_HEIGHT);
  localparam int GW = $clog2(NUM_SOURCES);

  sched_state_t     state;
  logic             expire;
  logic             last_src;
  logic             start_now;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [COLOR_DEPTH-1:0] sel_color;

  assign last_src  = (grant_sel == GW'(NUM_SOURCES - 1));
  assign start_now = (state == ST_START) && src_enable[grant_sel];

  // The start pulse goes only to the granted source, so at most one bit is set
  assign src_start = start_now ? (NUM_SOURCES'(1) << grant_sel) : '0;

  // Pick the granted source's address and color slices from the packed buses
  always_comb begin
    sel_x     = src_x_addr[int'(grant_sel)*XW +: XW];
    sel_y     = src_y_addr[int'(grant_sel)*YW +: YW];
    sel_color = src_color[int'(grant_sel)*COLOR_DEPTH +: COLOR_DEPTH];
  end

`ifdef FB_SCHED_TIMEOUT_EN
  logic in_draw;
  assign in_draw = (state == ST_DRAW);

  fb_sched_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .resetN(resetN),
    .run   (in_draw),
    .expire(expire)
  );

  // Remember which source was cut off; a real done on the same cycle wins
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeout_flags <= '0;
    end else if (in_draw && expire && !src_done[grant_sel]) begin
      timeout_flags[grant_sel] <= 1'b1;
    end
  end
`else
  // No watchdog: DRAW ends only on done (a negative limit cannot occur)
  assign expire        = (TIMEOUT_CYCLES < 0);
  assign timeout_flags = '0;
`endif

  // Frame sequencer: walk every source index in order, then report completion
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      grant_sel  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame) begin
            grant_sel <= '0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          state <= src_enable[grant_sel] ? ST_DRAW : ST_NEXT;
        end
        ST_DRAW: begin
          if (src_done[grant_sel] || expire) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_src) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            grant_sel <= grant_sel + 1'b1;
            state     <= ST_START;
          end
        end
        ST_DONE: begin
          grant_sel <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register the granted pixel one cycle after it is offered during DRAW
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      write_active      <= 1'b0;
      write_transparent <= 1'b0;
      write_x_addr      <= '0;
      write_y_addr      <= '0;
      write_color_data  <= '0;
    end else begin
      write_active <= (state == ST_DRAW) && src_valid[grant_sel];
      if ((state == ST_DRAW) && src_valid[grant_sel]) begin
        write_transparent <= src_transparent[grant_sel];
        write_x_addr      <= sel_x;
        write_y_addr      <= sel_y;
        write_color_data  <= sel_color;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler. Each draw engine is modelled
// as a random pixel list; the expected frame-buffer write stream is simply
// the enabled lists concatenated in source order.
// Define FB_SCHED_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_fb_write_scheduler;

  localparam int N  = 4;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int CD = 9;
  localparam int TO = 16;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int GW = $clog2(N);

  logic             clk = 1'b0;
  logic             resetN;
  logic             frame;
  logic [N-1:0]     src_enable, src_start, src_valid, src_done, src_transparent;
  logic [N*XW-1:0]  src_x_addr;
  logic [N*YW-1:0]  src_y_addr;
  logic [N*CD-1:0]  src_color;
  logic             write_active, write_transparent;
  logic [XW-1:0]    write_x_addr;
  logic [YW-1:0]    write_y_addr;
  logic [CD-1:0]    write_color_data;
  logic [GW-1:0]    grant_sel;
  logic             frame_done, overrun;
  logic [N-1:0]     timeout_flags;

  fb_write_scheduler #(
    .NUM_SOURCES(N), .DRAW_WIDTH(W), .DRAW_HEIGHT(H),
    .COLOR_DEPTH(CD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetN(resetN), .frame(frame),
    .src_enable(src_enable), .src_start(src_start),
    .src_valid(src_valid), .src_done(src_done),
    .src_x_addr(src_x_addr), .src_y_addr(src_y_addr),
    .src_color(src_color), .src_transparent(src_transparent),
    .write_active(write_active), .write_transparent(write_transparent),
    .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .write_color_data(write_color_data), .grant_sel(grant_sel),
    .frame_done(frame_done), .overrun(overrun), .timeout_flags(timeout_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CD-1:0] c;
    logic          t;
  } pix_t;

  pix_t src_pix [N][$];
  pix_t exp_q [$];
  bit   eng_active [N];
  int   start_cycle [N];
  int   grant_seq [$];
  int   errors, checks, cycle_no, frame_done_cnt, frame_done_cycle;
  int   start_cnt, writes, frame_lat, ov_delay;
  int   hang_src, noise_src, overrun_src;
  bit   exp_wa;
  pix_t exp_wp;
  logic [GW-1:0] last_grant;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Engines offer their next pixel most cycles and pulse done when empty,
  // sometimes on the same cycle as the last pixel.
  task automatic drive_sources();
    pix_t p;
    src_valid = '0;
    src_done  = '0;
    for (int i = 0; i < N; i++) begin
      src_x_addr[i*XW +: XW] = XW'($urandom_range(0, W - 1));
      src_y_addr[i*YW +: YW] = YW'($urandom_range(0, H - 1));
      src_color[i*CD +: CD]  = CD'($urandom);
      src_transparent[i]     = 1'($urandom);
    end
    exp_wa = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!eng_active[i] || i == hang_src) continue;
      if (src_pix[i].size() > 0 && $urandom_range(0, 7) != 0) begin
        p = src_pix[i].pop_front();
        src_x_addr[i*XW +: XW] = p.x;
        src_y_addr[i*YW +: YW] = p.y;
        src_color[i*CD +: CD]  = p.c;
        src_transparent[i]     = p.t;
        src_valid[i] = 1'b1;
        exp_wa = 1'b1;
        exp_wp = p;
        if (src_pix[i].size() == 0 && $urandom_range(0, 1) == 1) begin
          src_done[i]   = 1'b1;
          eng_active[i] = 1'b0;
        end
      end else if (src_pix[i].size() == 0) begin
        src_done[i]   = 1'b1;
        eng_active[i] = 1'b0;
      end
    end
    if (noise_src >= 0 && grant_sel == '0 && !eng_active[noise_src]) begin
      src_valid[noise_src] = 1'($urandom);
      src_done[noise_src]  = 1'($urandom);
    end
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs
  task automatic tick();
    pix_t p;
    @(posedge clk);
    @(negedge clk);
    cycle_no++;
    frame = 1'b0;
    check_output("write_active", write_active, exp_wa);
    if (write_active) begin
      writes++;
      check_output("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check_output("write_x", write_x_addr, p.x);
        check_output("write_y", write_y_addr, p.y);
        check_output("write_color", write_color_data, p.c);
        check_output("write_transp", write_transparent, p.t);
      end
    end
    if (frame_done) begin
      frame_done_cnt++;
      frame_done_cycle = cycle_no;
    end
    if (grant_sel != last_grant) begin
      grant_seq.push_back(int'(grant_sel));
      last_grant = grant_sel;
    end
    check_output("start_onehot0", $onehot0(src_start), 1);
    drive_sources();
    for (int i = 0; i < N; i++) begin
      if (src_start[i]) begin
        start_cnt++;
        start_cycle[i] = cycle_no;
        eng_active[i]  = 1'b1;
        check_output("start_grant", grant_sel, i);
        if (i == overrun_src) ov_delay = 2;
      end
    end
    if (ov_delay > 0) begin
      ov_delay--;
      if (ov_delay == 0) frame = 1'b1;
    end
  endtask

  // Build random pixel lists, pulse frame and run until frame_done or abort
  task automatic apply_stimulus(input logic [N-1:0] en, input int pmin,
                                input int pmax, input int abort_src);
    pix_t p;
    int   n, c0, budget;
    src_enable = en;
    exp_q.delete();
    grant_seq.delete();
    grant_seq.push_back(0);
    last_grant = '0;
    frame_done_cnt = 0;
    start_cnt = 0;
    writes = 0;
    for (int i = 0; i < N; i++) begin
      eng_active[i] = 1'b0;
      start_cycle[i] = -1;
      src_pix[i].delete();
      n = (i == hang_src) ? 0 : $urandom_range(pmin, pmax);
      for (int k = 0; k < n; k++) begin
        p.x = XW'($urandom_range(0, W - 1));
        p.y = YW'($urandom_range(0, H - 1));
        p.c = CD'($urandom);
        p.t = 1'($urandom);
        src_pix[i].push_back(p);
        if (en[i]) exp_q.push_back(p);
      end
    end
    frame = 1'b1;
    c0 = cycle_no;
    budget = 600;
    tick();
    while (budget > 0 && frame_done_cnt == 0) begin
      if (abort_src >= 0 && start_cycle[abort_src] >= 0 &&
          cycle_no >= start_cycle[abort_src] + 3) break;
      tick();
      budget--;
    end
    if (abort_src < 0) check_output("frame_done_in_budget", frame_done_cnt, 1);
    frame_lat = frame_done_cycle - c0;
  endtask

  // Let the bus settle, then confirm one completion and a full grant sweep
  task automatic finish_frame(input int exp_starts);
    repeat (12) tick();
    check_output("frame_done_count", frame_done_cnt, 1);
    check_output("pixels_left", exp_q.size(), 0);
    check_output("start_count", start_cnt, exp_starts);
    check_output("grant_seq_len", grant_seq.size(), N + 1);
    for (int i = 0; i < grant_seq.size() && i <= N; i++) begin
      check_output("grant_seq", grant_seq[i], (i == N) ? 0 : i);
    end
  endtask

  initial begin
    logic [N-1:0] en;
    errors = 0; checks = 0; cycle_no = 0; ov_delay = 0;
    hang_src = -1; noise_src = -1; overrun_src = -1;
    exp_wa = 1'b0; last_grant = '0;
    frame = 1'b0; src_enable = '0; src_valid = '0; src_done = '0;
    src_x_addr = '0; src_y_addr = '0; src_color = '0; src_transparent = '0;
    resetN = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_write_active", write_active, 0);
    check_output("rst_write_x", write_x_addr, 0);
    check_output("rst_write_color", write_color_data, 0);
    check_output("rst_grant", grant_sel, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_timeout", timeout_flags, 0);
    check_output("rst_start", src_start, 0);
    resetN = 1'b1;
    tick();
    tick();

    $display("[TB] all sources enabled, three pixels each");
    apply_stimulus(4'b1111, 3, 3, -1);
    check_output("writes_12", exp_q.size() + writes, 12);
    finish_frame(4);
    check_output("overrun_clear", overrun, 0);

    $display("[TB] random enable patterns and pixel counts");
    for (int r = 0; r < 6; r++) begin
      en = N'($urandom_range(1, 15));
      apply_stimulus(en, 1, 6, -1);
      finish_frame($countones(en));
    end

    $display("[TB] enable pattern 1010");
    apply_stimulus(4'b1010, 2, 5, -1);
    finish_frame(2);
    check_output("no_start_src0", start_cycle[0], -1);
    check_output("no_start_src2", start_cycle[2], -1);
    check_output("src3_after_src1", start_cycle[3] > start_cycle[1], 1);

    $display("[TB] all sources disabled");
    apply_stimulus(4'b0000, 1, 4, -1);
    check_output("disabled_latency", frame_lat, 2 * N + 1);
    finish_frame(0);
    check_output("disabled_writes", writes, 0);

    $display("[TB] non-granted source 3 noise while source 0 draws");
    noise_src = 3;
    apply_stimulus(4'b1111, 4, 6, -1);
    noise_src = -1;
    finish_frame(4);

`ifdef FB_SCHED_TIMEOUT_EN
    $display("[TB] source 1 never finishes");
    hang_src = 1;
    apply_stimulus(4'b1111, 2, 4, -1);
    finish_frame(4);
    check_output("timeout_exit", start_cycle[2] - start_cycle[1], TO + 2);
    check_output("timeout_flags", timeout_flags, 4'b0010);
    hang_src = -1;
`else
    check_output("timeout_tied", timeout_flags, 0);
`endif

    $display("[TB] second frame during source 2");
    overrun_src = 2;
    apply_stimulus(4'b1111, 3, 5, -1);
    overrun_src = -1;
    finish_frame(4);
    check_output("overrun_set", overrun, 1);
    apply_stimulus(4'b0110, 1, 4, -1);
    finish_frame(2);
    check_output("overrun_sticky", overrun, 1);

    $display("[TB] reset in the middle of source 2");
    apply_stimulus(4'b1111, 5, 6, 2);
    check_output("abort_in_src2", grant_sel, 2);
    resetN = 1'b0;
    #1;
    check_output("mid_rst_write_active", write_active, 0);
    check_output("mid_rst_write_y", write_y_addr, 0);
    check_output("mid_rst_grant", grant_sel, 0);
    check_output("mid_rst_start", src_start, 0);
    check_output("mid_rst_overrun", overrun, 0);
    check_output("mid_rst_timeout", timeout_flags, 0);
    exp_wa = 1'b0; src_valid = '0; src_done = '0;
    for (int i = 0; i < N; i++) eng_active[i] = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    tick();
    check_output("post_rst_frame_done", frame_done, 0);
    apply_stimulus(4'b1111, 2, 4, -1);
    finish_frame(4);

    $display("[TB] frame pulse on the DONE cycle");
    apply_stimulus(4'b1001, 1, 3, -1);
    frame = 1'b1;
    finish_frame(2);
    check_output("done_frame_overrun", overrun, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
